// File: rtl/ledr_drv_pkg.sv
// Shared definitions for the LEDR PWM driver: register map, reset values, blink phase type.
package ledr_drv_pkg;

    localparam logic [1:0] ADDR_BRIGHT   = 2'd0;
    localparam logic [1:0] ADDR_FADE_DIV = 2'd1;
    localparam logic [1:0] ADDR_STATUS   = 2'd2;
    localparam logic [1:0] ADDR_BLINK    = 2'd3;

    localparam int PWM_BITS_DEF = 8;
    localparam int PWM_MAX      = (1 << PWM_BITS_DEF) - 1;
    localparam int FADE_DIV_RST = 0;
    localparam int BLINK_RST    = 0;

    typedef enum logic {
        PHASE_LIT  = 1'b0,
        PHASE_DARK = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/ledr_fade_chan.sv
// One LED channel: brightness level that ramps toward its target, plus the PWM compare.
module ledr_fade_chan
    import ledr_drv_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] target,
    input  logic                instant,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out,
    output logic                mismatch
);

    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_nxt;

    always_comb begin
        level_nxt = level;
        if (instant) begin
            level_nxt = target;
        end else if (tick) begin
            if (level < target) begin
                level_nxt = level + ONE;
            end else if (level > target) begin
                level_nxt = level - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level   <= '0;
            pwm_out <= 1'b0;
        end else begin
            level   <= level_nxt;
            pwm_out <= (pwm_cnt < level);
        end
    end

    assign mismatch = (level != target);

endmodule

// File: rtl/ledr_pwm_driver.sv
// LEDR PWM driver top: Avalon register file, fade prescaler, PWM counter, per-LED channels.
// Optional blink support is compiled in when LEDR_BLINK_EN is defined.
module ledr_pwm_driver
    import ledr_drv_pkg::*;
#(
    parameter int N_LED      = 10,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_W    = 16,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_LED-1:0] pattern_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [N_LED-1:0] ledr_out,
    output logic             busy
);

    localparam logic [PWM_BITS-1:0] PWM_TOP  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_TOP - PWM_BITS'(1);

    logic                wr_en;
    logic [N_LED-1:0]    pattern_q;
    logic [PWM_BITS-1:0] bright_q;
    logic [PRESC_W-1:0]  fade_div_q;
    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                instant;
    logic [N_LED-1:0]    dark_mask;
    logic [N_LED-1:0]    status;
    logic                unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign tick         = (presc == fade_div_q);
    assign instant      = (fade_div_q == '0);
    assign unused_wdata = ^writedata[31:PRESC_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q  <= '0;
            bright_q   <= PWM_TOP;
            fade_div_q <= PRESC_W'(FADE_DIV_RST);
        end else begin
            pattern_q <= pattern_in;
            if (wr_en && address == ADDR_BRIGHT) begin
                bright_q <= writedata[PWM_BITS-1:0];
            end
            if (wr_en && address == ADDR_FADE_DIV) begin
                fade_div_q <= writedata[PRESC_W-1:0];
            end
        end
    end

    // A FADE_DIV write restarts the fade period so the new rate starts cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            if ((wr_en && address == ADDR_FADE_DIV) || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
        end
    end

`ifdef LEDR_BLINK_EN
    localparam logic [31:0] BLINK_RELOAD = 32'(BLINK_HALF - 1);

    logic [N_LED-1:0] blink_q;
    blink_phase_t     blink_phase;
    logic [31:0]      blink_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q     <= N_LED'(BLINK_RST);
            blink_phase <= PHASE_LIT;
            blink_cnt   <= BLINK_RELOAD;
        end else begin
            if (wr_en && address == ADDR_BLINK) begin
                blink_q <= writedata[N_LED-1:0];
            end
            if (blink_cnt == '0) begin
                blink_cnt   <= BLINK_RELOAD;
                blink_phase <= (blink_phase == PHASE_LIT) ? PHASE_DARK : PHASE_LIT;
            end else begin
                blink_cnt <= blink_cnt - 32'd1;
            end
        end
    end

    assign dark_mask = (blink_phase == PHASE_DARK) ? blink_q : '0;
`else
    assign dark_mask = '0;
`endif

    for (genvar i = 0; i < N_LED; i++) begin : g_chan
        logic [PWM_BITS-1:0] target;

        assign target = (pattern_q[i] && !dark_mask[i]) ? bright_q : '0;

        ledr_fade_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .target   (target),
            .instant  (instant),
            .tick     (tick),
            .pwm_cnt  (pwm_cnt),
            .pwm_out  (ledr_out[i]),
            .mismatch (status[i])
        );
    end

    assign busy = |status;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_BRIGHT:   readdata[PWM_BITS-1:0] = bright_q;
            ADDR_FADE_DIV: readdata[PRESC_W-1:0]  = fade_div_q;
            ADDR_STATUS:   readdata[N_LED-1:0]    = status;
`ifdef LEDR_BLINK_EN
            ADDR_BLINK:    readdata[N_LED-1:0]    = blink_q;
`endif
            default:       readdata = '0;
        endcase
    end

endmodule
